// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests win over fetch, with a streak limit.
// Optional MEM_ARB_STATS_EN adds per-requester completion counters.
module mem_arbiter #(
    parameter int DSTREAK_MAX = 4,
    parameter int CNT_W       = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount
`endif
);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    localparam logic [1:0]       ACCESS = 2'd2;
    localparam logic [CNT_W-1:0] SMAX   = CNT_W'(DSTREAK_MAX);

    state_t           r_state;
    logic [CNT_W-1:0] r_streak;

    logic w_dreq;
    logic w_access;
    logic w_idone;
    logic w_ddone;
    logic w_force_i;

    assign w_dreq    = dREN | dWEN;
    assign w_access  = (ramstate == ACCESS);
    assign w_idone   = (r_state == IGRANT) && iREN && w_access;
    assign w_ddone   = (r_state == DGRANT) && w_dreq && w_access;
    assign w_force_i = iREN && (r_streak >= SMAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_streak <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dreq && !w_force_i) begin
                        r_state <= DGRANT;
                        if (!iREN)
                            r_streak <= '0;
                        else if (r_streak < SMAX)
                            r_streak <= r_streak + 1'b1;
                    end else if (iREN) begin
                        r_state  <= IGRANT;
                        r_streak <= '0;
                    end
                end
                IGRANT: begin
                    if (!iREN || w_access)
                        r_state <= IDLE;
                end
                DGRANT: begin
                    if (!w_dreq || w_access)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Enables follow the live request so a withdrawal drops them at once
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (r_state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !w_idone;
                iload   = ramload;
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !w_ddone;
                dload    = ramload;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount <= '0;
            dcount <= '0;
        end else begin
            if (w_idone)
                icount <= icount + 32'd1;
            if (w_ddone)
                dcount <= dcount + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified RAM between the instruction-fetch requester and the data-memory requester.
- Data requests have priority over instruction fetches.
- A bounded streak counter keeps a continuous data stream from starving fetch.
- Sits between the fetch/memory pipeline stages and the RAM; it owns the ramREN/ramWEN/ramaddr/ramstore drive and the per-requester wait signals.

Parameters:
- DSTREAK_MAX, 4: maximum consecutive data grants while iREN is pending before fetch is forced to win the next grant.
- CNT_W, 3: width of the streak counter; must hold DSTREAK_MAX.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- iREN  input  1  instruction read request, level, held until iwait=0.
- iaddr  input  32  instruction address.
- iwait  output  1  1 = instruction request not yet complete.
- iload  output  32  instruction data, valid when iREN=1 and iwait=0.
- dREN  input  1  data read request, level.
- dWEN  input  1  data write request, level.
- daddr  input  32  data address.
- dstore  input  32  data to write.
- dwait  output  1  1 = data request not yet complete.
- dload  output  32  read data, valid when dREN=1 and dwait=0.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.
- ramload  input  32  RAM read data.
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- States: IDLE, IGRANT, DGRANT. Reset enters IDLE with streak=0.
- Reset outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
- IDLE: drives no RAM signals; iwait=1 and dwait=1. On the next edge:
  - If (dREN|dWEN) and not (iREN and streak>=DSTREAK_MAX): go to DGRANT; streak increments if iREN=1 (saturating), else clears to 0.
  - Else if iREN: go to IGRANT; streak clears to 0.
  - Else: stay in IDLE.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. dWEN wins if both are asserted.
  - dwait = (ramstate!=ACCESS). dload=ramload. iwait=1.
- IGRANT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - iwait = (ramstate!=ACCESS). iload=ramload. dwait=1.
- Completion: in the cycle where ramstate==ACCESS in a grant state, the owner's wait is 0 for exactly that cycle, and the FSM returns to IDLE on the next edge.
- Minimum latency: request in cycle 0, grant in cycle 1, earliest completion in cycle 1. Back-to-back requests from the same requester get one IDLE bubble.
- ramstate BUSY or FREE: hold the grant; wait stays 1.
- ramstate ERROR: hold the grant with wait=1 and keep driving. The request is retried implicitly; no abort.
- Requester withdraws mid-grant (its REN/WEN goes to 0 before completion): RAM enables drop in the same cycle combinationally, and the FSM returns to IDLE on the next edge. No completion pulse.
- Address or data changing mid-grant passes straight through; holding them stable is the requester's responsibility.
- Reset mid-grant: immediate IDLE; all RAM enables go to 0 asynchronously.
- Streak only counts data grants taken while iREN was pending. After a forced IGRANT, streak=0.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined, adds outputs icount[31:0] and dcount[31:0]. Each increments on a completion cycle of its requester, wraps modulo 2^32, and resets to 0.
- When undefined, those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- iREN=1, iaddr=0x40, ramstate BUSY for 2 cycles then ACCESS with ramload=0x8C010004 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 with iload=0x8C010004 only in cycle 3; IDLE in cycle 4.
- iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first with ramWEN=1 and ramstore=0xDEADBEEF; after the data completes, one IDLE cycle, then IGRANT.
- dREN held continuously with iREN=1, ramstate ACCESS every grant cycle -> grant order D,D,D,D,I,D,... (streak 4 forces fetch).
- DGRANT with ramstate=ERROR for 5 cycles then ACCESS -> dwait=1 for all 5 cycles with RAM signals stable; completion on cycle 6.
- dREN dropped in the second BUSY cycle of a DGRANT -> ramREN=0 in the same cycle, IDLE on the next edge, no dwait=0 pulse.
- nRST asserted mid-IGRANT -> ramREN=0 immediately and the FSM is in IDLE; with MEM_ARB_STATS_EN defined, icount=0 and dcount=0.
